// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
package uart_pkg;

   // Bits per character on the serial line (8N1 framing).
   localparam int DATA_BITS = 8;

   // CPU store address that the UART write strobe decodes; shared with the CPU.
   localparam logic [31:0] UART_TX_ADDR = 32'h1000_0000;

   // Transmitter FSM states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Single-clock byte FIFO with an explicit occupancy counter.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module uart_fifo #(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [7:0]       din,
   input  logic             pop,
   output logic [7:0]       dout,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [7:0]       mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_FULL);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   // Qualify push/pop and compute next pointers, count and storage contents.
   always_comb begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      mem_d    = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 1'b1;
      end
   end

   // Pointer and occupancy registers; reset discards all queued bytes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Byte storage; contents are only meaningful between the pointers, so no reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// CPU memory-mapped UART transmitter: queues the low byte of each store
// and serialises it as 8N1 at CLK_DIV clocks per bit.
module uart_tx_mmio
   import uart_pkg::*;
#(
   parameter int CLK_DIV    = 16,
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [31:0]      wr_data,
   input  logic             clr_overflow,
   output logic             tx,
   output logic             busy,
   output logic             fifo_empty,
   output logic             fifo_full,
   output logic [CNT_W-1:0] fifo_count,
   output logic             overflow
);

   localparam int BAUD_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
   localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

   tx_state_t              state_q, state_d;
   logic [BAUD_W-1:0]      baud_q, baud_d;
   logic [2:0]             bit_q, bit_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   tx_q, tx_d;
   logic                   overflow_q, overflow_d;
   logic                   pop;
   logic                   drop;
   logic [7:0]             head;
   logic                   unused_wr_hi;

   // Only the low byte of the store is transmitted.
   assign unused_wr_hi = ^wr_data[31:8];

   uart_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (wr_en),
      .din   (wr_data[7:0]),
      .pop   (pop),
      .dout  (head),
      .empty (fifo_empty),
      .full  (fifo_full),
      .count (fifo_count)
   );

   assign tx       = tx_q;
   assign busy     = (state_q != IDLE);
   assign overflow = overflow_q;

   // Framing FSM: next state, baud/bit counters, shift register, next tx level and FIFO pop.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = head;
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            if (baud_q == BAUD_LAST) begin
               baud_d  = '0;
               bit_d   = '0;
               tx_d    = shift_q[0];
               state_d = DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         DATA: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = '0;
               if (bit_q == BIT_LAST) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 3'd1;
                  tx_d    = shift_q[1];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         STOP: begin
            if (baud_q == BAUD_LAST) begin
               baud_d = '0;
               if (!fifo_empty) begin
                  // Chain straight into the next frame with no idle gap.
                  pop     = 1'b1;
                  shift_d = head;
                  bit_d   = '0;
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  tx_d    = 1'b1;
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   // Sticky overflow: a dropped write sets it and wins over a same-edge clear.
   always_comb begin
      drop       = wr_en && fifo_full && !pop;
      overflow_d = overflow_q;
      if (drop) begin
         overflow_d = 1'b1;
      end else if (clr_overflow) begin
         overflow_d = 1'b0;
      end
   end

   // Control and line registers; reset forces the line high at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         tx_q       <= 1'b1;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         tx_q       <= tx_d;
         overflow_q <= overflow_d;
      end
   end

   // Shift register holds only the byte in flight; it is reloaded on every pop.
   always_ff @(posedge clk) begin
      shift_q <= shift_d;
   end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio at CLK_DIV=4, FIFO_DEPTH=4.
module tb_uart_tx_mmio;

   localparam int CD    = 4;
   localparam int DEPTH = 4;
   localparam int CW    = 3;
   localparam int FRAME = 10 * CD;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [31:0]   wr_data;
   logic          clr_overflow;
   logic          tx;
   logic          busy;
   logic          fifo_empty;
   logic          fifo_full;
   logic [CW-1:0] fifo_count;
   logic          overflow;

   uart_tx_mmio #(
      .CLK_DIV    (CD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .clr_overflow (clr_overflow),
      .tx           (tx),
      .busy         (busy),
      .fifo_empty   (fifo_empty),
      .fifo_full    (fifo_full),
      .fifo_count   (fifo_count),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   // Reference: each accepted byte with the edge it was accepted on and the edge it leaves the FIFO.
   int         acc_q[$];
   int         pop_q[$];
   logic [7:0] dat_q[$];
   logic       ovf_m = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, got, want);
      end
   endtask

   function automatic void model_reset();
      acc_q.delete();
      pop_q.delete();
      dat_q.delete();
      ovf_m = 1'b0;
   endfunction

   // Decide what happens to a write presented for edge n.
   function automatic void model_edge(int n, logic we, logic [7:0] d, logic c);
      int   occ = 0;
      logic popn = 1'b0;
      logic accept;
      int   pe;
      foreach (pop_q[i]) begin
         if (acc_q[i] < n && pop_q[i] >= n) occ++;
         if (pop_q[i] == n) popn = 1'b1;
      end
      accept = we && (occ < DEPTH || popn);
      if (accept) begin
         pe = n + 1;
         if (pop_q.size() > 0 && pop_q[$] + FRAME > pe) pe = pop_q[$] + FRAME;
         acc_q.push_back(n);
         pop_q.push_back(pe);
         dat_q.push_back(d);
      end
      if (we && !accept) ovf_m = 1'b1;
      else if (c) ovf_m = 1'b0;
   endfunction

   // Compare every output against the reference for the state after edge cyc.
   task automatic expect_all();
      int         m = cyc;
      int         cnt = 0;
      int         ph;
      logic       etx = 1'b1;
      logic       ebusy = 1'b0;
      logic [9:0] fr;
      foreach (pop_q[i]) begin
         if (acc_q[i] <= m && pop_q[i] > m) cnt++;
         if (pop_q[i] <= m && m < pop_q[i] + FRAME) begin
            ebusy = 1'b1;
            ph    = (m - pop_q[i]) / CD;
            fr    = {1'b1, dat_q[i], 1'b0};
            etx   = fr[ph];
         end
      end
      chk("tx", tx, etx);
      chk("busy", busy, ebusy);
      chk("fifo_count", fifo_count, cnt);
      chk("fifo_empty", fifo_empty, cnt == 0);
      chk("fifo_full", fifo_full, cnt == DEPTH);
      chk("overflow", overflow, ovf_m);
   endtask

   // One clock: inputs driven at the falling edge, outputs checked at the next falling edge.
   task automatic cycle(input logic we, input logic [31:0] d, input logic c);
      wr_en        = we;
      wr_data      = d;
      clr_overflow = c;
      if (!rst) model_edge(cyc + 1, we, d[7:0], c);
      @(posedge clk);
      @(negedge clk);
      expect_all();
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((busy !== 1'b0 || fifo_empty !== 1'b1) && n < budget) begin
         cycle(1'b0, 32'h0, 1'b0);
         n++;
      end
      chk("idle_timeout", n < budget, 1'b1);
   endtask

   // Write one byte while idle and capture the line mid-bit for the whole frame.
   task automatic send_capture(input string tag, input logic [31:0] d, input logic [9:0] want);
      logic [9:0] seen = '0;
      int         nb = 0;
      cycle(1'b1, d, 1'b0);
      chk({tag, "_busy_pre"}, busy, 1'b0);
      for (int k = 0; k <= FRAME; k++) begin
         cycle(1'b0, 32'h0, 1'b0);
         if (k < FRAME && (k % CD) == 1) seen[k / CD] = tx;
         if (busy === 1'b1) nb++;
      end
      chk({tag, "_frame"}, seen, want);
      chk({tag, "_busy_len"}, nb, FRAME);
      chk({tag, "_end_tx"}, tx, 1'b1);
   endtask

   initial begin
      int         p;
      int         nb;
      int         rises;
      logic       prev;
      logic [31:0] rd;

      rst          = 1'b1;
      wr_en        = 1'b0;
      wr_data      = '0;
      clr_overflow = 1'b0;
      @(negedge clk);
      chk("rst_tx", tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_empty", fifo_empty, 1'b1);
      chk("rst_full", fifo_full, 1'b0);
      chk("rst_count", fifo_count, 0);
      chk("rst_ovf", overflow, 1'b0);
      cycle(1'b0, 32'h0, 1'b0);
      rst = 1'b0;
      repeat (3) cycle(1'b0, 32'h0, 1'b0);

      // Single byte and upper-bit masking.
      send_capture("b55", 32'h0000_0055, 10'b10_1010_1010);
      send_capture("b41", 32'h0000_0141, 10'b10_1000_0010);

      // Three back-to-back bytes form one contiguous busy run.
      nb    = 0;
      rises = 0;
      prev  = busy;
      cycle(1'b1, 32'h48, 1'b0);
      cycle(1'b1, 32'h69, 1'b0);
      cycle(1'b1, 32'h0A, 1'b0);
      nb = 2;
      rises = 1;
      prev = busy;
      for (int k = 0; k < 200 && busy === 1'b1; k++) begin
         cycle(1'b0, 32'h0, 1'b0);
         if (busy === 1'b1) nb++;
         if (busy === 1'b1 && prev !== 1'b1) rises++;
         prev = busy;
      end
      chk("b2b_busy_len", nb, 3 * FRAME);
      chk("b2b_busy_runs", rises, 1);
      wait_idle(100);

      // Overflow: six writes while idle, then clear racing a dropped write, then a clean clear.
      for (int k = 0; k < 6; k++) cycle(1'b1, $urandom, 1'b0);
      chk("ovf_set", overflow, 1'b1);
      chk("ovf_full", fifo_full, 1'b1);
      cycle(1'b1, $urandom, 1'b1);
      chk("ovf_set_wins", overflow, 1'b1);
      cycle(1'b0, 32'h0, 1'b1);
      chk("ovf_cleared", overflow, 1'b0);
      wait_idle(400);

      // Reset during DATA bit 3 with two bytes queued.
      cycle(1'b1, 32'hC3, 1'b0);
      p = pop_q[$];
      cycle(1'b1, 32'h5A, 1'b0);
      cycle(1'b1, 32'hA5, 1'b0);
      while (cyc < p + 4 * CD + 1) cycle(1'b0, 32'h0, 1'b0);
      chk("mid_count_pre", fifo_count, 2);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_tx", tx, 1'b1);
      chk("mid_rst_busy", busy, 1'b0);
      chk("mid_rst_count", fifo_count, 0);
      model_reset();
      @(negedge clk);
      repeat (2) cycle(1'b0, 32'h0, 1'b0);
      rst = 1'b0;
      repeat (3 * FRAME) cycle(1'b0, 32'h0, 1'b0);
      chk("post_rst_tx", tx, 1'b1);

      // Random traffic: sparse first, then dense enough to overflow.
      for (int k = 0; k < 3000; k++) begin
         rd = $urandom;
         cycle(($urandom_range(0, (k < 1500) ? 59 : 17) == 0), rd, ($urandom_range(0, 49) == 0));
      end
      wait_idle(600);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
